// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
// Optional build macro: MULDIV_FAST_SPECIAL_EN (see muldiv_unit).
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    function automatic logic is_div(input funct3_e f);
        return f[2];
    endfunction

    function automatic logic is_signed_rs1(input funct3_e f);
        return f inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_rs2(input funct3_e f);
        return f inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Control FSM for muldiv_unit: handshake, step counter, flush handling.
// fast_i (driven only when MULDIV_FAST_SPECIAL_EN is defined) ends CALC after the first step.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_i,
    input  logic flush_i,
    input  logic fast_i,
    output logic ready_o,
    output logic accept_o,
    output logic step_en_o,
    output logic load_result_o,
    output logic done_o
);

    localparam int unsigned CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ready_o       = 1'b0;
        accept_o      = 1'b0;
        step_en_o     = 1'b0;
        load_result_o = 1'b0;
        done_o        = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i && !flush_i) begin
                    accept_o = 1'b1;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (flush_i) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    step_en_o = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                    if (cnt_q == LAST || fast_i) begin
                        load_result_o = 1'b1;
                        cnt_d         = '0;
                        state_d       = DONE;
                    end
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one step per cycle.
// Define MULDIV_FAST_SPECIAL_EN to finish div-by-zero, signed overflow and zero-operand multiply in one step.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  iCLK,
    input  logic                  iRSTN,
    input  logic                  iValid,
    input  logic [2:0]            iFunct3,
    input  logic [DATA_WIDTH-1:0] iRS1,
    input  logic [DATA_WIDTH-1:0] iRS2,
    input  logic                  iFlush,
    output logic                  oReady,
    output logic                  oValid,
    output logic [DATA_WIDTH-1:0] oResult
);

    localparam int unsigned W = DATA_WIDTH;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    logic accept, step_en, load_result, done, fast;

    funct3_e        op_q, op_d, op_in;
    logic           neg_q, neg_d, special_q, special_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, spec_res_q, spec_res_d, result_q, result_d;
    logic [2*W-1:0] acc_q, acc_d, prod;

    logic           s1, s2, ge, div0, ovf, mzero;
    logic [W-1:0]   mag1, mag2, quo, rem;
    logic [W:0]     rem_shift, sum;

`ifdef MULDIV_FAST_SPECIAL_EN
    assign fast = special_q;
`else
    assign fast = 1'b0;
`endif

    muldiv_ctrl #(.DATA_WIDTH(DATA_WIDTH)) u_ctrl (
        .clk          (iCLK),
        .rst_n        (iRSTN),
        .valid_i      (iValid),
        .flush_i      (iFlush),
        .fast_i       (fast),
        .ready_o      (oReady),
        .accept_o     (accept),
        .step_en_o    (step_en),
        .load_result_o(load_result),
        .done_o       (done)
    );

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            op_q       <= OP_MUL;
            neg_q      <= 1'b0;
            special_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            spec_res_q <= '0;
            result_q   <= '0;
            acc_q      <= '0;
        end else begin
            op_q       <= op_d;
            neg_q      <= neg_d;
            special_q  <= special_d;
            a_q        <= a_d;
            b_q        <= b_d;
            spec_res_q <= spec_res_d;
            result_q   <= result_d;
            acc_q      <= acc_d;
        end
    end

    always_comb begin
        op_d       = op_q;
        neg_d      = neg_q;
        special_d  = special_q;
        a_d        = a_q;
        b_d        = b_q;
        spec_res_d = spec_res_q;
        result_d   = result_q;
        acc_d      = acc_q;

        op_in = funct3_e'(iFunct3);
        s1    = is_signed_rs1(op_in) && iRS1[W-1];
        s2    = is_signed_rs2(op_in) && iRS2[W-1];
        mag1  = s1 ? -iRS1 : iRS1;
        mag2  = s2 ? -iRS2 : iRS2;
        div0  = is_div(op_in) && (iRS2 == '0);
        ovf   = (op_in == OP_DIV || op_in == OP_REM) && (iRS1 == MOST_NEG) && (iRS2 == '1);
        mzero = !is_div(op_in) && (iRS1 == '0 || iRS2 == '0);

        rem_shift = acc_q[2*W-1:W-1];
        ge        = rem_shift >= {1'b0, b_q};
        sum       = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);

        if (accept) begin
            op_d       = op_in;
            neg_d      = (is_div(op_in) && op_in[1]) ? s1 : (s1 ^ s2);
            a_d        = mag1;
            b_d        = mag2;
            acc_d      = {{W{1'b0}}, is_div(op_in) ? mag1 : mag2};
            special_d  = div0 || ovf || mzero;
            spec_res_d = '0;
            if (div0)
                spec_res_d = op_in[1] ? iRS1 : '1;
            else if (ovf)
                spec_res_d = op_in[1] ? '0 : MOST_NEG;
        end else if (step_en) begin
            if (is_div(op_q))
                acc_d = {ge ? rem_shift[W-1:0] - b_q : rem_shift[W-1:0], acc_q[W-2:0], ge};
            else
                acc_d = {sum, acc_q[W-1:1]};
        end

        // Sign correction uses the post-step accumulator so the last step and negate share one edge.
        prod = neg_q ? -acc_d : acc_d;
        quo  = neg_q ? -acc_d[W-1:0] : acc_d[W-1:0];
        rem  = neg_q ? -acc_d[2*W-1:W] : acc_d[2*W-1:W];

        if (load_result) begin
            if (special_q)
                result_d = spec_res_q;
            else begin
                unique case (op_q)
                    OP_MUL:                       result_d = prod[W-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod[2*W-1:W];
                    OP_DIV, OP_DIVU:              result_d = quo;
                    default:                      result_d = rem;
                endcase
            end
        end
    end

    assign oValid  = done;
    assign oResult = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors queued at acceptance, checked by a monitor on oValid.
module tb_muldiv_unit;

    localparam int W = 32;

    logic          iCLK = 1'b0;
    logic          iRSTN = 1'b0;
    logic          iValid = 1'b0;
    logic [2:0]    iFunct3 = 3'b000;
    logic [W-1:0]  iRS1 = '0;
    logic [W-1:0]  iRS2 = '0;
    logic          iFlush = 1'b0;
    logic          oReady, oValid;
    logic [W-1:0]  oResult;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
        int           acc_cyc;
        string        name;
    } exp_t;

    exp_t sb[$];

    muldiv_unit #(.DATA_WIDTH(W)) dut (
        .iCLK   (iCLK),
        .iRSTN  (iRSTN),
        .iValid (iValid),
        .iFunct3(iFunct3),
        .iRS1   (iRS1),
        .iRS2   (iRS2),
        .iFlush (iFlush),
        .oReady (oReady),
        .oValid (oValid),
        .oResult(oResult)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every oValid pulse must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge iCLK);
            if (iRSTN && oValid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got result 0x%08h with no outstanding request", oResult);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, oResult, e.res);
                    check({e.name, "_latency"}, W'(cyc - e.acc_cyc), W'(e.lat));
                end
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input bit spec, input bit track, input string nm);
        exp_t e;
        int n;
        n = 0;
        @(negedge iCLK);
        while (!oReady && n < 100) begin
            @(negedge iCLK);
            n++;
        end
        iValid = 1'b1; iFunct3 = f; iRS1 = a; iRS2 = b;
        @(posedge iCLK);
        #1;
        iValid = 1'b0;
        if (track) begin
            e.res = exp;
`ifdef MULDIV_FAST_SPECIAL_EN
            e.lat = spec ? 1 : W;
`else
            e.lat = W;
`endif
            e.acc_cyc = cyc;
            e.name = nm;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge iCLK);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge iCLK);
    endtask

    task automatic run(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input bit spec, input string nm);
        issue(f, a, b, exp, spec, 1'b1, nm);
        wait_drain();
    endtask

    initial begin
        #1;
        check("reset_ready", W'(oReady), W'(1));
        check("reset_valid", W'(oValid), W'(0));
        check("reset_result", oResult, '0);
        repeat (2) @(negedge iCLK);
        iRSTN = 1'b1;

        run(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul");
        run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu");
        run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "mulh");
        run(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, "mulhsu");
        run(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, "div");
        run(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, "rem");
        run(3'b101, 32'd100, 32'd7, 32'd14, 1'b0, "divu");
        run(3'b111, 32'd100, 32'd7, 32'd2, 1'b0, "remu");
        run(3'b101, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 1'b1, "divu_by0");
        run(3'b111, 32'h0000_1234, 32'h0, 32'h0000_1234, 1'b1, "remu_by0");
        run(3'b100, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFFF, 1'b1, "div_neg_by0");
        run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf");
        run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "rem_ovf");

        // Flush a divide before edge 10; no result may appear.
        issue(3'b100, 32'd1000, 32'd3, '0, 1'b0, 1'b0, "flushed");
        repeat (10) @(negedge iCLK);
        check("flush_ready_before", W'(oReady), W'(0));
        iFlush = 1'b1;
        @(posedge iCLK);
        #1;
        iFlush = 1'b0;
        check("flush_ready_after", W'(oReady), W'(1));
        repeat (40) @(negedge iCLK);
        run(3'b000, 32'd3, 32'd5, 32'd15, 1'b0, "mul_after_flush");

        // Asynchronous reset mid-operation.
        issue(3'b000, 32'd9, 32'd9, '0, 1'b0, 1'b0, "reset_victim");
        repeat (5) @(negedge iCLK);
        iRSTN = 1'b0;
        #1;
        check("midreset_valid", W'(oValid), W'(0));
        check("midreset_result", oResult, '0);
        check("midreset_ready", W'(oReady), W'(1));
        @(negedge iCLK);
        iRSTN = 1'b1;
        repeat (40) @(negedge iCLK);

        // iValid held with changing operands while busy must be ignored.
        issue(3'b000, 32'd6, 32'd7, 32'd42, 1'b0, 1'b1, "mul_busy");
        for (int i = 0; i < 20; i++) begin
            iValid = 1'b1; iFunct3 = 3'b011;
            iRS1 = $urandom; iRS2 = $urandom;
            @(negedge iCLK);
        end
        iValid = 1'b0;
        wait_drain();
        repeat (40) @(negedge iCLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
